// File: rtl/sample_mul_share_arb_if.sv
// sample_mul_share_arb_if: requester and response bus of the shared-multiplier arbiter
interface sample_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 11,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_p;
    logic                      rsp_ready;
    modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_id, rsp_p);
    modport slave  (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_id, rsp_p);
endinterface

// File: rtl/sample_mul_share_arb.sv
// sample_mul_share_arb: round-robin sharing of one pipelined signed multiplier with tag return
module sample_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 11,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    sample_mul_share_arb_if.slave        bus,
    output logic                         mul_ce,
    output logic [DATA_W-1:0]            mul_din0,
    output logic [DATA_W-1:0]            mul_din1,
    input  logic [DATA_W-1:0]            mul_dout,
    output logic [$clog2(MUL_LAT+1)-1:0] inflight
);
    localparam int IW = $clog2(MUL_LAT + 1);
    logic [ID_W-1:0]    ptr, gid, cand;
    logic               hs, stall;
    logic [MUL_LAT-1:0] tv;
    logic [ID_W-1:0]    tid [MUL_LAT];

    // only an unaccepted response freezes the pipe; reset keeps it flowing
    assign stall  = |bus.rsp_valid & ~bus.rsp_ready & ~reset;
    assign mul_ce = ~stall;

    // round-robin search starting just past the last winner, operands muxed from the winner
    always_comb begin
        hs = 1'b0;
        gid = '0;
        cand = '0;
        mul_din0 = '0;
        mul_din1 = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!hs && !stall && !reset && bus.req_valid[cand]) begin
                hs = 1'b1;
                gid = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (hs && gid == ID_W'(i)) begin
                mul_din0 = bus.req_a[i*DATA_W +: DATA_W];
                mul_din1 = bus.req_b[i*DATA_W +: DATA_W];
            end
        bus.req_ready = NUM_REQ'(hs) << gid;
    end

    // tag valids and pointer advance together with the multiplier
    always_ff @(posedge clk)
        if (reset) begin
            ptr <= ID_W'(NUM_REQ - 1);
            tv  <= '0;
        end else if (mul_ce) begin
            tv <= MUL_LAT'({tv, hs});
            if (hs)
                ptr <= gid;
        end

    // tag ids need no reset since their valid bits mask them
    always_ff @(posedge clk)
        if (mul_ce) begin
            tid[0] <= gid;
            for (int k = MUL_LAT - 1; k >= 1; k--)
                tid[k] <= tid[k-1];
        end

    assign bus.rsp_valid = NUM_REQ'(tv[MUL_LAT-1]) << tid[MUL_LAT-1];
    assign bus.rsp_id    = tv[MUL_LAT-1] ? tid[MUL_LAT-1] : '0;
    assign bus.rsp_p     = mul_dout;
    assign inflight      = IW'($countones(tv));
endmodule

// File: tb/tb_sample_mul_share_arb.sv
// tb_sample_mul_share_arb: directed table plus corner-case sequences for the multiplier arbiter
module tb_sample_mul_share_arb;
    localparam int N = 4;
    localparam int W = 11;
    localparam int L = 2;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mul_ce;
    logic [W-1:0] mul_din0, mul_din1, mul_dout;
    logic [1:0] inflight;
    logic signed [W-1:0] a_r, b_r, p_r;
    logic signed [2*W-1:0] full;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
    } vec_t;
    vec_t vt [7];

    sample_mul_share_arb_if #(.NUM_REQ(N), .DATA_W(W), .ID_W(IDW)) bus();

    sample_mul_share_arb #(.NUM_REQ(N), .DATA_W(W), .MUL_LAT(L), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .mul_ce(mul_ce),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // 2-stage ce-gated signed multiplier, operand then product register
    assign full = a_r * b_r;
    assign mul_dout = p_r;
    always_ff @(posedge clk)
        if (mul_ce) begin
            a_r <= mul_din0;
            b_r <= mul_din1;
            p_r <= full[W-1:0];
        end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic opnd(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{2, 11'd3,   11'd5,   11'd15};
        vt[1] = '{0, 11'h7F9, 11'd9,   11'h7C1};
        vt[2] = '{1, 11'd40,  11'd40,  11'h640};
        vt[3] = '{3, 11'h7FF, 11'h7FF, 11'd1};
        vt[4] = '{3, 11'h400, 11'h7FF, 11'h400};
        vt[5] = '{1, 11'd0,   11'd123, 11'd0};
        vt[6] = '{2, 11'd31,  11'd33,  11'h3FF};
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        step;
        bus.req_valid = 4'hF;
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mul_ce", mul_ce, 1);
        step;
        reset = 1'b0;
        bus.req_valid = '0;
        #2;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_inflight", inflight, 0);
        step;

        for (int i = 0; i < 7; i++) begin
            bus.req_valid = 4'b0001 << vt[i].id;
            opnd(vt[i].id, vt[i].a, vt[i].b);
            #2;
            chk("vec_grant", bus.req_ready, 32'd1 << vt[i].id);
            step;
            bus.req_valid = '0;
            #2;
            chk("vec_inflight", inflight, 1);
            step;
            #2;
            chk("vec_rsp_valid", bus.rsp_valid, 32'd1 << vt[i].id);
            chk("vec_rsp_id", bus.rsp_id, vt[i].id);
            chk("vec_rsp_p", bus.rsp_p, vt[i].p);
            step;
        end

        do_reset;
        for (int i = 0; i < N; i++) opnd(i, W'(i + 1), 11'd10);
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #2;
            chk("fair_grant", bus.req_ready, (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 2) begin
                chk("fair_rsp_valid", bus.rsp_valid, 32'd1 << ((c - 2) % 4));
                chk("fair_rsp_id", bus.rsp_id, (c - 2) % 4);
                chk("fair_rsp_p", bus.rsp_p, ((c - 2) % 4 + 1) * 10);
            end else
                chk("fair_rsp_idle", bus.rsp_valid, 0);
            step;
        end

        do_reset;
        for (int i = 0; i < N; i++) opnd(i, W'(i + 2), 11'd3);
        bus.req_valid = 4'b0001;
        #2;
        chk("bp_grant0", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = 4'b0010;
        #2;
        chk("bp_grant1", bus.req_ready, 4'b0010);
        step;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_hold_valid", bus.rsp_valid, 4'b0001);
            chk("bp_hold_id", bus.rsp_id, 0);
            chk("bp_hold_p", bus.rsp_p, 6);
            chk("bp_hold_ce", mul_ce, 0);
            chk("bp_hold_ready", bus.req_ready, 0);
            chk("bp_hold_din", mul_din0, 0);
            step;
        end
        bus.rsp_ready = 1'b1;
        #2;
        chk("bp_rel_valid", bus.rsp_valid, 4'b0001);
        chk("bp_rel_grant", bus.req_ready, 4'b0100);
        chk("bp_rel_ce", mul_ce, 1);
        step;
        bus.req_valid = '0;
        #2;
        chk("bp_rsp1_valid", bus.rsp_valid, 4'b0010);
        chk("bp_rsp1_p", bus.rsp_p, 9);
        step;
        #2;
        chk("bp_rsp2_valid", bus.rsp_valid, 4'b0100);
        chk("bp_rsp2_id", bus.rsp_id, 2);
        chk("bp_rsp2_p", bus.rsp_p, 12);
        step;
        #2;
        chk("bp_drain_valid", bus.rsp_valid, 0);
        chk("bp_drain_inflight", inflight, 0);
        step;

        bus.req_valid = 4'b0001;
        #2;
        chk("mr_grant0", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = 4'b0010;
        #2;
        chk("mr_grant1", bus.req_ready, 4'b0010);
        step;
        bus.req_valid = '0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        bus.req_valid = 4'b1001;
        #2;
        chk("mr_rsp_valid", bus.rsp_valid, 0);
        chk("mr_inflight", inflight, 0);
        chk("mr_grant_after", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = '0;
        #2;
        chk("mr_discard", bus.rsp_valid, 0);
        chk("mr_inflight1", inflight, 1);
        step;
        #2;
        chk("mr_new_valid", bus.rsp_valid, 4'b0001);
        chk("mr_new_p", bus.rsp_p, 6);
        step;
        #2;
        chk("mr_idle", bus.rsp_valid, 0);
        step;

        do_reset;
        opnd(0, 11'd5, 11'd5);
        opnd(1, 11'd7, 11'd7);
        bus.req_valid = 4'b0011;
        #2;
        chk("wd_grant0", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = 4'b0001;
        #2;
        chk("wd_regrant0", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = '0;
        #2;
        chk("wd_none", bus.req_ready, 0);
        chk("wd_rsp_a", bus.rsp_valid, 4'b0001);
        chk("wd_rsp_p", bus.rsp_p, 25);
        step;
        #2;
        chk("wd_rsp_b", bus.rsp_valid, 4'b0001);
        chk("wd_rsp_id", bus.rsp_id, 0);
        step;
        #2;
        chk("wd_idle", bus.rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
